dm_cache_ctrl: RTL and testbench
================================

# dm_cache_ctrl

Parametrised direct-mapped cache controller, one word per line. It sits between the CPU request port and main memory. It holds valid/tag/data state per line and decides hit or miss by tag compare. It refills lines on read misses, writes through to memory on every store, and supports a single-cycle flush. It keeps saturating hit and miss counters.

## Interface
Parameters:
- ADDR_W, 20: word-address width.
- DATA_W, 32: data word width.
- INDEX_W, 6: index bits; number of lines is 2^INDEX_W. Tag width is ADDR_W-INDEX_W.
- CNT_W, 16: width of the hit and miss counters.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept; equals (state==IDLE) && !flush.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address; index = low INDEX_W bits, tag = upper bits.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load data; valid with resp_valid on loads.
- resp_hit  out  1  lookup result, qualified by resp_valid.
- mem_req_valid  out  1  memory request, held until accepted.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_resp_valid  in  1  read data returned or write acknowledged.
- mem_rdata  in  DATA_W  memory read data.
- hit_count, miss_count  out  CNT_W  saturating counters.

## Operation
- **States:**
  - IDLE: accept a request, or apply flush.
  - LOOKUP: tag compare on the registered request.
  - MEM_REQ: issue the memory request.
  - MEM_WAIT: wait for the memory response.
- **IDLE:** flush has priority over req_valid; req_ready is 0 while flush is high. Flush clears every valid bit in one cycle. Tag and data arrays are untouched. On req_valid && req_ready, latch we/addr/wdata and go to LOOKUP.
- **LOOKUP:** hit = valid[index] && tag[index]==req tag.
  - Load hit: resp_valid=1, resp_rdata=data[index], resp_hit=1; go to IDLE. hit_count increments.
  - Load miss: go to MEM_REQ with mem_req_we=0. miss_count increments.
  - Store hit: data[index] is written with wdata. Go to MEM_REQ with mem_req_we=1. hit_count increments.
  - Store miss: no allocate; the line is unchanged. Go to MEM_REQ with mem_req_we=1. miss_count increments.
- **MEM_REQ:** mem_req_valid=1 with stable addr, we and wdata until the cycle mem_req_ready=1, then go to MEM_WAIT.
- **MEM_WAIT:** on mem_resp_valid go to IDLE and pulse resp_valid with resp_hit equal to the LOOKUP result.
  - Loads: data[index] is set to mem_rdata, tag[index] to the request tag, valid[index] to 1, and resp_rdata is set to mem_rdata.
  - Stores: resp_rdata is don't-care.
- mem_resp_valid outside MEM_WAIT is ignored.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset in any state, including mid-refill:
  - state goes to IDLE;
  - all valid bits, both counters, resp_valid and mem_req_valid go to 0;
  - resp_rdata goes to 0;
  - any memory response already in flight is ignored.

## Timing
- All outputs are registered except req_ready, which is decoded from state and flush.
- Reset values: req_ready=1 after reset (IDLE, flush low), resp_valid=0, resp_hit=0, resp_rdata=0, mem_req_valid=0, mem_req_we=0, mem_addr=0, mem_wdata=0, both counters 0.
- Load hit: accepted at edge E0, resp_valid high in the cycle after E1. This is 2-cycle latency. req_ready is high in that same cycle, giving a peak rate of one request every 2 cycles.
- Miss or store: mem_req_valid rises in the cycle after E1.
  - Minimum total latency is 4 cycles when mem_req_ready and mem_resp_valid are each high on first opportunity.
  - mem_resp_valid in the same cycle as mem_req_ready acceptance is not consumed; it must arrive in MEM_WAIT.
- resp_valid is high for exactly one cycle per accepted request.

## Structure
- Package dm_cache_pkg holds:
  - the state enum (IDLE, LOOKUP, MEM_REQ, MEM_WAIT);
  - default parameter constants;
  - a tag-width function.
- Sub-module dm_cache_line_array holds the valid vector, tag array and data array. It provides:
  - asynchronous read by index;
  - one write port (tag/data/valid);
  - a flush-all input.
- The controller FSM and counters live in dm_cache_ctrl.

## Test plan
All tests use ADDR_W=20, INDEX_W=4, CNT_W=4.
1. Cold load 0x00013: miss, mem read of 0x00013 returns 0xDEADBEEF. Expect resp_rdata=0xDEADBEEF, resp_hit=0. Repeat the load: hit in 2 cycles, no mem_req_valid.
2. Conflict: load 0x00013, then load 0x00023 (same index 3, different tag). Expect a miss and a refill. Then reload 0x00013: miss again.
3. Store 0x00013 of 0x12345678 after scenario 1. Expect a hit, a mem write with addr 0x00013 and wdata 0x12345678, and a subsequent load hit returning 0x12345678. Store to uncached 0x00045: miss, write-through only, next load of 0x00045 misses.
4. Flush and req_valid high together in IDLE. Expect req_ready=0 and the request not accepted that cycle. Every previously cached address then misses.
5. Hold mem_req_ready low for 5 cycles during a refill. Expect mem_req_valid and mem_addr stable throughout. Assert rst while in MEM_WAIT, then drive mem_resp_valid. Expect no resp_valid, and all lines invalid.
6. Issue 20 load hits. Expect hit_count to saturate at 15 and miss_count unchanged.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared types, default sizes and helpers for the direct-mapped cache controller.
package dm_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT
  } state_e;

  localparam int unsigned DEF_ADDR_W  = 20;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_INDEX_W = 6;
  localparam int unsigned DEF_CNT_W   = 16;

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU request/response and main-memory handshake bundle for dm_cache_ctrl.
// slave = the cache controller, master = the CPU/memory side driving it.
interface dm_cache_ctrl_if
  import dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  flush, req_valid, req_we, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
    output mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );

  modport master (
    output flush, req_valid, req_we, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
    input  mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache: async read, one write port,
// single-cycle flush of all valid bits (tag and data arrays are left as they are).
module dm_cache_line_array
  import dm_cache_pkg::*;
#(
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned TAG_W   = tag_width(DEF_ADDR_W, DEF_INDEX_W),
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [DATA_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               wr_valid_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]  wr_data_i
);
  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Reset wins over a write so a response landing during reset never validates a line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one word
// per line, single-cycle flush and saturating hit/miss counters.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  dm_cache_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W);

  state_e              state_q;
  logic                req_we_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic                lookup_hit_q;
  logic                resp_valid_q;
  logic                resp_hit_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                mem_req_valid_q;
  logic                mem_req_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]    hit_cnt_q,  hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [DATA_W-1:0]   line_data;
  logic                hit;
  logic                req_fire;
  logic                arr_flush;
  logic                arr_we;
  logic [DATA_W-1:0]   arr_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign bus.req_ready = (state_q == IDLE) && !bus.flush;
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign arr_flush     = (state_q == IDLE) && bus.flush;

  assign req_idx = req_addr_q[INDEX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];
  assign hit     = line_valid && (line_tag == req_tag);

  // Store hits update the line in LOOKUP; load refills write in MEM_WAIT.
  always_comb begin
    arr_we    = 1'b0;
    arr_wdata = req_wdata_q;
    if ((state_q == LOOKUP) && req_we_q && hit) begin
      arr_we = 1'b1;
    end else if ((state_q == MEM_WAIT) && bus.mem_resp_valid && !req_we_q) begin
      arr_we    = 1'b1;
      arr_wdata = bus.mem_rdata;
    end
  end

  dm_cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (arr_flush),
    .rd_idx_i   (req_idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (arr_we),
    .wr_idx_i   (req_idx),
    .wr_valid_i (1'b1),
    .wr_tag_i   (req_tag),
    .wr_data_i  (arr_wdata)
  );

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP) begin
      if (hit) hit_cnt_d  = sat_inc(hit_cnt_q);
      else     miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  // Accepted request is held here for the rest of the transaction.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_we_q    <= bus.req_we;
      req_addr_q  <= bus.req_addr;
      req_wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      lookup_hit_q    <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (req_fire) state_q <= LOOKUP;
        end
        LOOKUP: begin
          lookup_hit_q <= hit;
          if (hit && !req_we_q) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_rdata_q <= line_data;
            state_q      <= IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_req_we_q    <= req_we_q;
            mem_addr_q      <= req_addr_q;
            mem_wdata_q     <= req_wdata_q;
            state_q         <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_resp_valid) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= lookup_hit_q;
            if (!req_we_q) resp_rdata_q <= bus.mem_rdata;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_we    = mem_req_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign hit_count         = hit_cnt_q;
  assign miss_count        = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed vector table, corner-case sequences and random
// traffic checked against an array-based cache/memory reference model.
module tb_dm_cache_ctrl;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  int            total = 0;
  int            bad   = 0;

  dm_cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dm_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    logic [31:0] rdata;
    int          lat;
    bit          saw_mem;
    bit          mem_we;
    logic [19:0] maddr;
    logic [31:0] mwd;
    bit          stable;
    bit          timeout;
    bit          one_pulse;
    bit          rdy_at_resp;
  } obs_t;

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [31:0] wd;
    int          rdly;
    int          rspd;
    bit          early;
    bit          exp_hit;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  // Reference model: cache lines, backing memory, counters.
  bit          m_valid [16];
  logic [15:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] mem_store [logic [19:0]];
  int          m_hits, m_miss;
  vec_t        tv [8];

  function automatic logic [31:0] mem_read(input logic [19:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {12'hC0D, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_op(input bit we, input logic [19:0] a, input logic [31:0] wd,
                          output bit ehit, output logic [31:0] erd);
    int          idx;
    logic [15:0] t;
    idx  = int'(a[3:0]);
    t    = a[19:4];
    ehit = m_valid[idx] && (m_tag[idx] == t);
    if (ehit) m_hits = (m_hits < 15) ? m_hits + 1 : 15;
    else      m_miss = (m_miss < 15) ? m_miss + 1 : 15;
    erd = '0;
    if (we) begin
      mem_store[a] = wd;
      if (ehit) m_data[idx] = wd;
    end else begin
      erd = ehit ? m_data[idx] : mem_read(a);
      if (!ehit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = t;
        m_data[idx]  = erd;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_clear();
    m_hits = 0;
    m_miss = 0;
  endtask

  // Issues one request from IDLE and plays the memory side with the given delays.
  task automatic run_op(input bit we, input logic [19:0] a, input logic [31:0] wd,
                        input int rdly, input int rspd, input bit early, output obs_t o);
    int cnt;
    int phase;
    bit done;
    o = '{default: 0};
    o.stable = 1'b1;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    cnt = 0; phase = 0; done = 1'b0;
    for (int c = 1; c <= 80 && !done; c++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (bus.resp_valid) begin
        done = 1'b1;
        o.lat = c; o.hit = bus.resp_hit; o.rdata = bus.resp_rdata;
        o.rdy_at_resp = bus.req_ready;
      end else if (phase == 0 && bus.mem_req_valid) begin
        if (!o.saw_mem) begin
          o.saw_mem = 1'b1; o.mem_we = bus.mem_req_we;
          o.maddr = bus.mem_addr; o.mwd = bus.mem_wdata;
        end else if (bus.mem_req_we != o.mem_we || bus.mem_addr != o.maddr || bus.mem_wdata != o.mwd) begin
          o.stable = 1'b0;
        end
        if (cnt == rdly) begin
          bus.mem_req_ready = 1'b1;
          phase = 1; cnt = 0;
          if (early) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata = 32'hBAD0_0000 | 32'(c);
          end
        end else begin
          cnt++;
        end
      end else if (phase == 1) begin
        if (bus.mem_req_valid) o.stable = 1'b0;
        if (cnt == rspd) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata = we ? 32'h5A5A_0001 : mem_read(a);
          phase = 2;
        end else begin
          cnt++;
        end
      end
      @(negedge clk);
    end
    o.timeout   = !done;
    o.one_pulse = done && !bus.resp_valid;
  endtask

  task automatic verify_op(input string nm, input bit we, input logic [19:0] a, input logic [31:0] wd,
                           input int rdly, input int rspd, input bit early, output obs_t o);
    bit          ehit;
    logic [31:0] erd;
    bit          emem;
    int          elat;
    model_op(we, a, wd, ehit, erd);
    run_op(we, a, wd, rdly, rspd, early, o);
    emem = we || !ehit;
    elat = emem ? 4 + rdly + rspd : 2;
    chk({nm, ".timeout"}, 64'(o.timeout), 64'(0));
    chk({nm, ".hit"}, 64'(o.hit), 64'(ehit));
    if (!we) chk({nm, ".rdata"}, 64'(o.rdata), 64'(erd));
    chk({nm, ".latency"}, 64'(o.lat), 64'(elat));
    chk({nm, ".memreq"}, 64'(o.saw_mem), 64'(emem));
    if (emem) begin
      chk({nm, ".mem_we"}, 64'(o.mem_we), 64'(we));
      chk({nm, ".mem_addr"}, 64'(o.maddr), 64'(a));
      if (we) chk({nm, ".mem_wdata"}, 64'(o.mwd), 64'(wd));
      chk({nm, ".mem_stable"}, 64'(o.stable), 64'(1));
    end
    chk({nm, ".one_pulse"}, 64'(o.one_pulse), 64'(1));
    chk({nm, ".ready_at_resp"}, 64'(o.rdy_at_resp), 64'(1));
    chk({nm, ".hit_count"}, 64'(hit_count), 64'(m_hits));
    chk({nm, ".miss_count"}, 64'(miss_count), 64'(m_miss));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t        o;
    bit          ehit;
    logic [31:0] erd;
    bit          seen;
    bit          found;
    logic [15:0] rt;
    logic [3:0]  ri;

    //           we  addr        wd            rdly rspd early hit  rdata         lat
    tv[0] = '{1'b0, 20'h00013, 32'h0,          0,   0,   1'b0, 1'b0, 32'hDEADBEEF, 4};
    tv[1] = '{1'b0, 20'h00013, 32'h0,          0,   0,   1'b0, 1'b1, 32'hDEADBEEF, 2};
    tv[2] = '{1'b0, 20'h00023, 32'h0,          0,   0,   1'b1, 1'b0, 32'h0BADF00D, 4};
    tv[3] = '{1'b0, 20'h00013, 32'h0,          2,   1,   1'b0, 1'b0, 32'hDEADBEEF, 7};
    tv[4] = '{1'b1, 20'h00013, 32'h12345678,   0,   0,   1'b0, 1'b1, 32'h0,        4};
    tv[5] = '{1'b0, 20'h00013, 32'h0,          0,   0,   1'b0, 1'b1, 32'h12345678, 2};
    tv[6] = '{1'b1, 20'h00045, 32'hCAFEF00D,   1,   2,   1'b1, 1'b0, 32'h0,        7};
    tv[7] = '{1'b0, 20'h00045, 32'h0,          0,   0,   1'b0, 1'b0, 32'hCAFEF00D, 4};

    mem_store[20'h00013] = 32'hDEADBEEF;
    mem_store[20'h00023] = 32'h0BADF00D;

    do_reset();
    #1;
    chk("reset.req_ready", 64'(bus.req_ready), 64'(1));
    chk("reset.resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("reset.resp_hit", 64'(bus.resp_hit), 64'(0));
    chk("reset.resp_rdata", 64'(bus.resp_rdata), 64'(0));
    chk("reset.mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("reset.mem_req_we", 64'(bus.mem_req_we), 64'(0));
    chk("reset.mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("reset.mem_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("reset.hit_count", 64'(hit_count), 64'(0));
    chk("reset.miss_count", 64'(miss_count), 64'(0));
    @(negedge clk);

    // Directed table: cold miss, hit, conflict, store hit/miss, no-allocate.
    for (int i = 0; i < 8; i++) begin
      model_op(tv[i].we, tv[i].addr, tv[i].wd, ehit, erd);
      run_op(tv[i].we, tv[i].addr, tv[i].wd, tv[i].rdly, tv[i].rspd, tv[i].early, o);
      chk($sformatf("vec%0d.timeout", i), 64'(o.timeout), 64'(0));
      chk($sformatf("vec%0d.hit", i), 64'(o.hit), 64'(tv[i].exp_hit));
      if (!tv[i].we) chk($sformatf("vec%0d.rdata", i), 64'(o.rdata), 64'(tv[i].exp_rd));
      chk($sformatf("vec%0d.latency", i), 64'(o.lat), 64'(tv[i].exp_lat));
      chk($sformatf("vec%0d.memreq", i), 64'(o.saw_mem), 64'(tv[i].exp_lat != 2));
      if (tv[i].exp_lat != 2) begin
        chk($sformatf("vec%0d.mem_addr", i), 64'(o.maddr), 64'(tv[i].addr));
        chk($sformatf("vec%0d.mem_we", i), 64'(o.mem_we), 64'(tv[i].we));
        if (tv[i].we) chk($sformatf("vec%0d.mem_wdata", i), 64'(o.mwd), 64'(tv[i].wd));
        chk($sformatf("vec%0d.mem_stable", i), 64'(o.stable), 64'(1));
      end
      chk($sformatf("vec%0d.one_pulse", i), 64'(o.one_pulse), 64'(1));
    end
    chk("table.hit_count", 64'(hit_count), 64'(3));
    chk("table.miss_count", 64'(miss_count), 64'(5));

    // Flush and request together: request must be refused, lines invalidated.
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 20'h00013;
    #1;
    chk("flush.req_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    model_clear();
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.resp_valid || bus.mem_req_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush.not_accepted", 64'(seen), 64'(0));
    verify_op("flush.ld13", 1'b0, 20'h00013, 32'h0, 0, 0, 1'b0, o);
    chk("flush.ld13_miss", 64'(o.hit), 64'(0));
    verify_op("flush.ld45", 1'b0, 20'h00045, 32'h0, 0, 0, 1'b0, o);
    chk("flush.ld45_miss", 64'(o.hit), 64'(0));

    // Refill with memory holding off acceptance for 5 cycles.
    verify_op("stall.ld99", 1'b0, 20'h00099, 32'h0, 5, 0, 1'b0, o);

    // Reset while waiting for a refill response.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 20'h00077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.mem_req_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("rstwait.memreq_seen", 64'(found), 64'(1));
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hFEEDFACE;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.resp_valid) seen = 1'b1;
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
    end
    chk("rstwait.no_resp", 64'(seen), 64'(0));
    chk("rstwait.mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("rstwait.resp_rdata", 64'(bus.resp_rdata), 64'(0));
    chk("rstwait.hit_count", 64'(hit_count), 64'(0));
    chk("rstwait.miss_count", 64'(miss_count), 64'(0));
    chk("rstwait.req_ready", 64'(bus.req_ready), 64'(1));
    model_clear();
    m_hits = 0;
    m_miss = 0;
    verify_op("rstwait.ld13", 1'b0, 20'h00013, 32'h0, 0, 0, 1'b0, o);
    chk("rstwait.ld13_miss", 64'(o.hit), 64'(0));
    verify_op("rstwait.ld99", 1'b0, 20'h00099, 32'h0, 0, 0, 1'b0, o);
    chk("rstwait.ld99_miss", 64'(o.hit), 64'(0));
    verify_op("rstwait.ld77", 1'b0, 20'h00077, 32'h0, 0, 0, 1'b0, o);
    chk("rstwait.ld77_miss", 64'(o.hit), 64'(0));

    // Hit counter saturation.
    do_reset();
    verify_op("sat.first", 1'b0, 20'h00021, 32'h0, 0, 0, 1'b0, o);
    for (int i = 0; i < 20; i++) verify_op($sformatf("sat.hit%0d", i), 1'b0, 20'h00021, 32'h0, 0, 0, 1'b0, o);
    chk("sat.hit_count", 64'(hit_count), 64'(15));
    chk("sat.miss_count", 64'(miss_count), 64'(1));

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_clear();
      end
      rt = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2));
      ri = 4'($urandom);
      verify_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 2) == 0), {rt, ri}, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
